// File: rtl/jp_pkg.sv
// Shared definitions for the emulated NES joypad: button indices and FSM encoding.
package jp_pkg;

  localparam int JP_NUM_BTNS   = 8;
  localparam int JP_BTN_A      = 0;
  localparam int JP_BTN_B      = 1;
  localparam int JP_BTN_SELECT = 2;
  localparam int JP_BTN_START  = 3;
  localparam int JP_BTN_UP     = 4;
  localparam int JP_BTN_DOWN   = 5;
  localparam int JP_BTN_LEFT   = 6;
  localparam int JP_BTN_RIGHT  = 7;

  localparam logic [3:0] JP_SHIFT_MAX = 4'd8;

  typedef enum logic [1:0] {
    JP_IDLE,
    JP_LOAD,
    JP_SHIFT,
    JP_DONE
  } jp_state_e;

endpackage

// File: rtl/jp_emu_if.sv
// Joypad serial line as seen between host controller (master) and pad (slave).
interface jp_emu_if;
  logic jp_latch;
  logic jp_clk;
  logic jp_data;

  modport master (output jp_latch, output jp_clk, input jp_data);
  modport slave  (input jp_latch, input jp_clk, output jp_data);
endinterface

// File: rtl/jp_sync_filt.sv
// Synchronizer, glitch filter and rising-edge detect for one asynchronous host line.
module jp_sync_filt #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4
) (
  input  logic clk,
  input  logic nres,
  input  logic din,
  output logic lvl,
  output logic rise
);

  localparam logic [3:0] FILT_LAST = 4'(FILT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [3:0]             filt_cnt;
  logic                   samp;

  assign samp = sync_q[SYNC_STAGES-1];

  // Level only moves after FILT_CYCLES consecutive samples disagree with it.
  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      sync_q   <= '0;
      filt_cnt <= '0;
      lvl      <= 1'b0;
      rise     <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      rise   <= 1'b0;
      if (samp == lvl) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        lvl      <= samp;
        rise     <= samp;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/jp_emu.sv
// Emulated NES joypad (4021-style PISO). Optional turbo masking: define JP_EMU_TURBO_EN.
module jp_emu
  import jp_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4,
  parameter int TURBO_DIV   = 4
) (
  input  logic                   clk,
  input  logic                   nres,
  jp_emu_if.slave                bus,
  input  logic [JP_NUM_BTNS-1:0] btn_in,
  input  logic [1:0]             turbo_en,
  output logic [3:0]             shift_cnt,
  output logic                   frame_strb
);

  localparam logic [7:0] TURBO_LAST = 8'(TURBO_DIV - 1);

  jp_state_e              state, state_nxt;
  logic [JP_NUM_BTNS-1:0] shreg, shreg_nxt;
  logic [JP_NUM_BTNS-1:0] masked_btn;
  logic [3:0]             cnt_nxt;
  logic                   strb_nxt;
  logic                   latch_lvl, latch_rise, clk_lvl, clk_rise;
  logic                   unused_edges;

  jp_sync_filt #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) u_latch_filt (
    .clk (clk), .nres(nres), .din(bus.jp_latch), .lvl(latch_lvl), .rise(latch_rise)
  );

  jp_sync_filt #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) u_clk_filt (
    .clk (clk), .nres(nres), .din(bus.jp_clk), .lvl(clk_lvl), .rise(clk_rise)
  );

  assign unused_edges = latch_rise ^ clk_lvl;

`ifdef JP_EMU_TURBO_EN
  logic [7:0] turbo_cnt;
  logic       turbo_phase;

  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      turbo_cnt   <= '0;
      turbo_phase <= 1'b1;
    end else if (frame_strb) begin
      if (turbo_cnt == TURBO_LAST) begin
        turbo_cnt   <= '0;
        turbo_phase <= ~turbo_phase;
      end else begin
        turbo_cnt <= turbo_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    masked_btn = btn_in;
    if (turbo_en[0] && !turbo_phase) masked_btn[JP_BTN_A] = 1'b0;
    if (turbo_en[1] && !turbo_phase) masked_btn[JP_BTN_B] = 1'b0;
  end
`else
  logic unused_turbo;
  assign masked_btn   = btn_in;
  assign unused_turbo = ^{turbo_en, TURBO_LAST};
`endif

  // A high latch always reloads, so it beats a coincident clock edge.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = shift_cnt;
    strb_nxt  = 1'b0;
    case (state)
      JP_IDLE: begin
        shreg_nxt = '1;
        if (latch_lvl) begin
          state_nxt = JP_LOAD;
          shreg_nxt = ~masked_btn;
          cnt_nxt   = '0;
        end
      end
      JP_LOAD: begin
        shreg_nxt = ~masked_btn;
        cnt_nxt   = '0;
        if (!latch_lvl) begin
          state_nxt = JP_SHIFT;
          strb_nxt  = 1'b1;
        end
      end
      JP_SHIFT: begin
        if (latch_lvl) begin
          state_nxt = JP_LOAD;
          shreg_nxt = ~masked_btn;
          cnt_nxt   = '0;
        end else if (clk_rise) begin
          shreg_nxt = {1'b0, shreg[JP_NUM_BTNS-1:1]};
          cnt_nxt   = shift_cnt + 4'd1;
          if (cnt_nxt == JP_SHIFT_MAX) state_nxt = JP_DONE;
        end
      end
      JP_DONE: begin
        shreg_nxt = '0;
        if (latch_lvl) begin
          state_nxt = JP_LOAD;
          shreg_nxt = ~masked_btn;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = JP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      state       <= JP_IDLE;
      shreg       <= '1;
      shift_cnt   <= '0;
      frame_strb  <= 1'b0;
      bus.jp_data <= 1'b1;
    end else begin
      state       <= state_nxt;
      shreg       <= shreg_nxt;
      shift_cnt   <= cnt_nxt;
      frame_strb  <= strb_nxt;
      bus.jp_data <= shreg_nxt[0];
    end
  end

endmodule

// File: tb/tb_jp_emu.sv
// Directed bench for jp_emu: read sequence, saturation, glitch rejection, latch priority, reset.
module tb_jp_emu;

  logic       clk = 1'b0;
  logic       nres;
  logic [7:0] btn_in;
  logic [1:0] turbo_en;
  logic [3:0] shift_cnt;
  logic       frame_strb;
  int         errors = 0;
  int         checks = 0;
  int         strb_cnt = 0;
  int         strb_base;
  logic [7:0] exp_seq;

  jp_emu_if bus();

  jp_emu dut (
    .clk       (clk),
    .nres      (nres),
    .bus       (bus),
    .btn_in    (btn_in),
    .turbo_en  (turbo_en),
    .shift_cnt (shift_cnt),
    .frame_strb(frame_strb)
  );

  always #10 clk = ~clk;

  always @(posedge clk) if (frame_strb) strb_cnt <= strb_cnt + 1;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clk_pulse;
    bus.jp_clk = 1'b1;
    cyc(12);
    bus.jp_clk = 1'b0;
    cyc(12);
  endtask

  task automatic latch_frame;
    bus.jp_latch = 1'b1;
    cyc(20);
    bus.jp_latch = 1'b0;
    cyc(12);
  endtask

  initial begin
    nres         = 1'b0;
    bus.jp_latch = 1'b0;
    bus.jp_clk   = 1'b0;
    btn_in       = 8'h00;
    turbo_en     = 2'b00;
    cyc(3);
    chk("rst_data", 8'(bus.jp_data), 8'd1);
    chk("rst_cnt", 8'(shift_cnt), 8'd0);
    chk("rst_strb", 8'(frame_strb), 8'd0);
    nres = 1'b1;
    cyc(5);
    chk("idle_data", 8'(bus.jp_data), 8'd1);

    // Frame 1: A+Start, with latch-acceptance latency
    btn_in    = 8'b0000_1001;
    exp_seq   = 8'hF6;
    strb_base = strb_cnt;
    bus.jp_latch = 1'b1;
    cyc(6);
    chk("lat_pre", 8'(bus.jp_data), 8'd1);
    cyc(1);
    chk("lat_acc", 8'(bus.jp_data), 8'd0);
    cyc(13);
    bus.jp_latch = 1'b0;
    cyc(12);
    chk("f1_bit0", 8'(bus.jp_data), 8'(exp_seq[0]));
    chk("f1_cnt0", 8'(shift_cnt), 8'd0);
    for (int i = 1; i < 8; i++) begin
      clk_pulse();
      chk($sformatf("f1_bit%0d", i), 8'(bus.jp_data), 8'(exp_seq[i]));
      chk($sformatf("f1_cnt%0d", i), 8'(shift_cnt), 8'(i));
    end
    clk_pulse();
    chk("f1_cnt8", 8'(shift_cnt), 8'd8);
    chk("f1_data8", 8'(bus.jp_data), 8'd0);
    chk("f1_strb", 8'(strb_cnt - strb_base), 8'd1);
    clk_pulse();
    chk("clk9_data", 8'(bus.jp_data), 8'd0);
    chk("clk9_cnt", 8'(shift_cnt), 8'd8);
    clk_pulse();
    chk("clk10_data", 8'(bus.jp_data), 8'd0);
    chk("clk10_cnt", 8'(shift_cnt), 8'd8);

    // Glitch rejection mid-shift: Right pressed only
    btn_in = 8'h80;
    latch_frame();
    repeat (3) clk_pulse();
    chk("gl_pre_cnt", 8'(shift_cnt), 8'd3);
    bus.jp_clk = 1'b1;
    cyc(2);
    bus.jp_clk = 1'b0;
    cyc(15);
    chk("gl_cnt", 8'(shift_cnt), 8'd3);
    chk("gl_data", 8'(bus.jp_data), 8'd1);

    // Clocks while latch held are ignored
    btn_in       = 8'h01;
    bus.jp_latch = 1'b1;
    cyc(20);
    for (int i = 0; i < 3; i++) begin
      clk_pulse();
      chk($sformatf("lh_data%0d", i), 8'(bus.jp_data), 8'd0);
      chk($sformatf("lh_cnt%0d", i), 8'(shift_cnt), 8'd0);
    end
    bus.jp_latch = 1'b0;
    cyc(12);
    clk_pulse();
    chk("lh_after_cnt", 8'(shift_cnt), 8'd1);
    chk("lh_after_data", 8'(bus.jp_data), 8'd1);

    // Latch and clock rising together: latch wins
    btn_in       = 8'h02;
    bus.jp_latch = 1'b1;
    bus.jp_clk   = 1'b1;
    cyc(20);
    chk("sim_cnt", 8'(shift_cnt), 8'd0);
    chk("sim_data", 8'(bus.jp_data), 8'd1);
    bus.jp_latch = 1'b0;
    bus.jp_clk   = 1'b0;
    cyc(12);
    chk("sim_bit0", 8'(bus.jp_data), 8'd1);
    clk_pulse();
    chk("sim_bit1", 8'(bus.jp_data), 8'd0);
    chk("sim_cnt1", 8'(shift_cnt), 8'd1);

    // Asynchronous reset mid-shift
    btn_in = 8'hA5;
    latch_frame();
    repeat (3) clk_pulse();
    chk("nr_pre_cnt", 8'(shift_cnt), 8'd3);
    nres = 1'b0;
    #1;
    chk("nr_data", 8'(bus.jp_data), 8'd1);
    chk("nr_cnt", 8'(shift_cnt), 8'd0);
    cyc(2);
    nres = 1'b1;
    cyc(3);
    exp_seq = ~btn_in;
    latch_frame();
    chk("nr_bit0", 8'(bus.jp_data), 8'(exp_seq[0]));
    for (int i = 1; i < 8; i++) begin
      clk_pulse();
      chk($sformatf("nr_bit%0d", i), 8'(bus.jp_data), 8'(exp_seq[i]));
    end

`ifdef JP_EMU_TURBO_EN
    // Turbo A at TURBO_DIV=4: host sees A pressed on frames 0-3, 8-11
    nres = 1'b0;
    cyc(2);
    nres     = 1'b1;
    turbo_en = 2'b01;
    btn_in   = 8'h01;
    cyc(3);
    for (int f = 0; f < 16; f++) begin
      latch_frame();
      chk($sformatf("turbo_f%0d", f), 8'(~bus.jp_data), 8'(((f / 4) % 2) == 0));
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jp_emu.md
# jp_emu

Emulated NES joypad: the device end of the joypad serial protocol, which the host joypad controller drives through `jp_latch`/`jp_clk`.
- Behaves like a 4021 parallel-in/serial-out shift register.
- Samples an 8-bit button vector from an on-board source and shifts it out on `jp_data`.
- Used for loopback verification of the host joypad controller and for driving a console from FPGA-side input.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer depth on `jp_latch`/`jp_clk` (min 2).
- FILT_CYCLES, 4: consecutive equal synchronized samples required before a level change is accepted (1..15).
- TURBO_DIV, 4: latch pulses per turbo phase toggle (1..255).

Ports:
- clk  in  1  50 MHz system clock
- nres  in  1  asynchronous active-low reset
- jp_latch  in  1  host latch, asynchronous to clk, active high
- jp_clk  in  1  host shift clock, asynchronous; shift on rising edge
- btn_in  in  8  buttons, active high: [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right
- turbo_en  in  2  [0] turbo A, [1] turbo B
- jp_data  out  1  serial line, raw polarity: 0 = pressed
- shift_cnt  out  4  bits shifted since last latch, 0..8
- frame_strb  out  1  one-cycle pulse on accepted latch falling edge

## Operation
- Input conditioning:
  - `jp_latch` and `jp_clk` each pass through a SYNC_STAGES flop chain, then a glitch filter.
  - Filtered level changes only after FILT_CYCLES identical samples.
  - Edges are detected on the filtered levels.
- Shift register `shreg[7:0]` holds raw line values, so bit = ~button.
- FSM states:
  - IDLE (after reset): `shreg`=8'hFF; `jp_data` is `shreg[0]`; jp_clk edges ignored. Filtered latch high → LOAD.
  - LOAD: `shreg` ← ~masked_btn every cycle; `shift_cnt`=0; rising jp_clk ignored, because load dominates. Filtered latch fall → SHIFT, and `frame_strb` pulses.
  - SHIFT: each filtered jp_clk rise does `shreg` ← {1'b0, `shreg[7:1]`} and `shift_cnt`+1. When `shift_cnt` reaches 8 → DONE. Filtered latch high → LOAD.
  - DONE: `shreg`=0, so `jp_data`=0 (host reads 1, like an official pad). Further clocks have no effect; `shift_cnt` saturates at 8. Filtered latch high → LOAD.
- Simultaneous filtered latch rise and jp_clk rise in one cycle: latch wins, no shift.
- `jp_data` = `shreg[0]`, driven from a flop.
- Masking (turbo): masked_btn = btn_in with bit0 cleared when turbo_en[0]&&!phase, and bit1 cleared when turbo_en[1]&&!phase.
- Turbo counter: 8-bit count of `frame_strb` pulses. On reaching TURBO_DIV-1 it wraps to 0 and phase toggles.

## Timing
- Reset values: `jp_data`=1, `shift_cnt`=0, `frame_strb`=0, state IDLE, `shreg`=8'hFF, turbo count=0, phase=1.
- Pin-to-accept latency: SYNC_STAGES+FILT_CYCLES clk cycles (6 at defaults); `jp_data` updates 1 cycle later.
- Host pulses narrower than FILT_CYCLES cycles are rejected. Host timing (12 µs latch, 6 µs clock half-period) is far above this.
- `btn_in` is sampled every cycle in LOAD; the value held on the last LOAD cycle is the one shifted out.
- nres assertion at any point (mid-shift, mid-latch) returns to reset values immediately. After deassertion, behaviour resumes from IDLE on the next latch.

## Configuration
- `JP_EMU_TURBO_EN` defined: turbo masking and the turbo counter are built as described.
- Undefined: masked_btn = btn_in; `turbo_en` is ignored; the counter and phase are not instantiated.
- The port list is identical in both builds.

## Structure
- Shared package `jp_pkg`:
  - button index constants `JP_BTN_A`..`JP_BTN_RIGHT`
  - FSM state encoding (IDLE, LOAD, SHIFT, DONE)
  - `JP_NUM_BTNS`=8
- One sub-module `jp_sync_filt` (synchronizer plus glitch filter plus edge detect), instantiated twice: once for latch, once for clk.

## Test plan
- After reset with no latch: `jp_data`=1, `shift_cnt`=0.
- btn_in=8'b0000_1001 (A, Start), latch pulse, then 8 clocks → `jp_data` sequence 0,1,1,0,1,1,1,1; `frame_strb` one pulse; `shift_cnt`=8.
- 9th and 10th clock → `jp_data`=0, `shift_cnt` stays 8.
- 2-cycle glitch on jp_clk during SHIFT → no shift; `shift_cnt` unchanged.
- jp_clk toggled while latch high with btn_in=8'h01 → `jp_data` stays 0, `shift_cnt`=0.
- nres pulsed after 3 shifts → `jp_data`=1, `shift_cnt`=0. Next full read matches btn_in.
- With `JP_EMU_TURBO_EN`, turbo_en=2'b01, A held, TURBO_DIV=4, 16 frames → first bit reads 1 (pressed) on frames 0-3, 8-11 and 0 on frames 4-7, 12-15 (first bit is `jp_data` inverted, as the host reads it).
